// File: rtl/manch_pkg.sv
// Shared types and encoding constants for the Manchester frame transmitter.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package manch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    // Line level driven during the first half of a one / zero bit.
    localparam logic MANCH_ONE_FIRST  = 1'b0;
    localparam logic MANCH_ZERO_FIRST = 1'b1;

    // Value of the first preamble bit; subsequent bits alternate.
    localparam logic PRE_START = 1'b1;

endpackage

// File: rtl/manch_half_enc.sv
// Maps {bit, phase} to a Manchester line level and registers it with its enable.
// Latency: 1 clock from bit_val/phase/en to line_out/line_en.
// Backpressure: none; follows the controller every cycle.
module manch_half_enc
    import manch_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic bit_val,
    input  logic phase,
    input  logic en,
    output logic line_out,
    output logic line_en
);

    logic first_half;

    assign first_half = bit_val ? MANCH_ONE_FIRST : MANCH_ZERO_FIRST;

    always_ff @(posedge clk) begin
        if (!rst) begin
            line_out <= 1'b0;
            line_en  <= 1'b0;
        end else begin
            line_en  <= en;
            line_out <= en & (phase ? ~first_half : first_half);
        end
    end

endmodule

// File: rtl/manchester_tx_ctrl.sv
// Self-timed Manchester frame transmitter: preamble, LSB-first data, [parity], stop.
// Latency: first half-bit on line the cycle after accept; MANCH_PARITY_EN adds a parity bit.
// Backpressure: tx_ready only in IDLE; host words are ignored while a frame is in flight.
module manchester_tx_ctrl
    import manch_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int PRE_LEN  = 4,
    parameter int HALF_DIV = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              line_out,
    output logic              line_en,
    output logic              busy,
    output logic              done
);

    localparam int CNT_MAX = (PRE_LEN > DATA_W) ? PRE_LEN : DATA_W;
    localparam int BC_W    = $clog2(CNT_MAX + 1);
    localparam int HC_W    = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

    localparam logic [HC_W-1:0] HALF_LAST = HC_W'(HALF_DIV - 1);
    localparam logic [BC_W-1:0] PRE_LAST  = BC_W'((PRE_LEN > 0) ? PRE_LEN - 1 : 0);
    localparam logic [BC_W-1:0] DATA_LAST = BC_W'(DATA_W - 1);

    state_t              state, state_nxt;
    logic [HC_W-1:0]     half_cnt, half_nxt;
    logic                phase, phase_nxt;
    logic [BC_W-1:0]     bit_cnt, bcnt_nxt;
    logic [DATA_W-1:0]   shreg, shreg_nxt;
    logic                done_nxt;
    logic                half_wrap, bit_end;
    logic                drv_bit, drv_en;
`ifdef MANCH_PARITY_EN
    logic                par_q, par_nxt;
`endif

    assign tx_ready  = (state == IDLE) && rst;
    assign busy      = (state != IDLE);
    assign half_wrap = (half_cnt == HALF_LAST);
    assign bit_end   = half_wrap && phase;

    always_comb begin
        state_nxt = state;
        half_nxt  = half_cnt;
        phase_nxt = phase;
        bcnt_nxt  = bit_cnt;
        shreg_nxt = shreg;
        done_nxt  = 1'b0;
        drv_bit   = 1'b0;
        drv_en    = 1'b0;
`ifdef MANCH_PARITY_EN
        par_nxt   = par_q;
`endif

        if (state == IDLE) begin
            if (tx_valid && tx_ready) begin
                shreg_nxt = tx_data;
                half_nxt  = '0;
                phase_nxt = 1'b0;
                bcnt_nxt  = '0;
`ifdef MANCH_PARITY_EN
                par_nxt   = ^tx_data;
`endif
                state_nxt = (PRE_LEN > 0) ? PREAMBLE : DATA;
            end
        end else begin
            if (half_wrap) begin
                half_nxt  = '0;
                phase_nxt = ~phase;
            end else begin
                half_nxt  = half_cnt + 1'b1;
            end

            if (bit_end) begin
                bcnt_nxt = bit_cnt + 1'b1;
                case (state)
                    PREAMBLE: begin
                        if (bit_cnt == PRE_LAST) begin
                            state_nxt = DATA;
                            bcnt_nxt  = '0;
                        end
                    end
                    DATA: begin
                        shreg_nxt = shreg >> 1;
                        if (bit_cnt == DATA_LAST) begin
`ifdef MANCH_PARITY_EN
                            state_nxt = PARITY;
`else
                            state_nxt = STOP;
`endif
                            bcnt_nxt  = '0;
                        end
                    end
`ifdef MANCH_PARITY_EN
                    PARITY: begin
                        state_nxt = STOP;
                        bcnt_nxt  = '0;
                    end
`endif
                    STOP: begin
                        state_nxt = IDLE;
                        bcnt_nxt  = '0;
                        done_nxt  = 1'b1;
                    end
                    default: ;
                endcase
            end
        end

        // The encoder registers its input, so feed it the half-bit of the coming cycle.
        case (state_nxt)
            PREAMBLE: begin
                drv_bit = PRE_START ^ bcnt_nxt[0];
                drv_en  = 1'b1;
            end
            DATA: begin
                drv_bit = shreg_nxt[0];
                drv_en  = 1'b1;
            end
`ifdef MANCH_PARITY_EN
            PARITY: begin
                drv_bit = par_nxt;
                drv_en  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            half_cnt <= '0;
            phase    <= 1'b0;
            bit_cnt  <= '0;
            shreg    <= '0;
            done     <= 1'b0;
`ifdef MANCH_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            half_cnt <= half_nxt;
            phase    <= phase_nxt;
            bit_cnt  <= bcnt_nxt;
            shreg    <= shreg_nxt;
            done     <= done_nxt;
`ifdef MANCH_PARITY_EN
            par_q    <= par_nxt;
`endif
        end
    end

    manch_half_enc u_enc (
        .clk      (clk),
        .rst      (rst),
        .bit_val  (drv_bit),
        .phase    (phase_nxt),
        .en       (drv_en),
        .line_out (line_out),
        .line_en  (line_en)
    );

endmodule
